// File: rtl/note_event_controller.sv
// ---------------------------------------------------------------------------
// note_event_controller
//
// Front end for the ADSR envelope generator. Parses a MIDI-style byte stream
// (Note On / Note Off for one channel, with running status) and runs a
// single-voice controller that issues note_on / note_off pulses. A new note
// is never started while the previous release is still running: a note that
// arrives during release is parked in a one-deep pending slot and launched
// when the generator reports env_done.
//
// Ports
//   clk        clock
//   rst_b      asynchronous active-low reset
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   byte accepted when in_valid && in_ready
//   env_done   generator done (one-cycle high on the last RELEASE cycle)
//   env_busy   generator busy (status only, consistency check in simulation)
//   note_on    one-cycle start pulse to the generator
//   note_off   one-cycle release pulse to the generator
//   key        current note number
//   velocity   current note velocity
//   active     voice not idle
// ---------------------------------------------------------------------------
module note_event_controller #(
    parameter int unsigned CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       env_done,
    input  logic       env_busy,
    output logic       note_on,
    output logic       note_off,
    output logic [6:0] key,
    output logic [6:0] velocity,
    output logic       active
);

    localparam logic [3:0] CH = 4'(CHANNEL);

    typedef enum logic [1:0] {
        P_STATUS   = 2'd0,
        P_DATA1    = 2'd1,
        P_DATA2    = 2'd2,
        P_DISPATCH = 2'd3
    } parse_t;

    typedef enum logic [1:0] {
        V_IDLE = 2'd0,
        V_ON   = 2'd1,
        V_REL  = 2'd2
    } voice_t;

    // ---------------- parser state ----------------
    parse_t     parse_q, parse_d;
    logic       rs_valid_q, rs_valid_d;   // running status present
    logic       rs_on_q, rs_on_d;         // running status type: 1 = Note On
    logic [6:0] data1_q, data1_d;
    logic [6:0] data2_q, data2_d;
    logic       in_ready_q, in_ready_d;

    // ---------------- voice state ----------------
    voice_t     voice_q, voice_d;
    logic [6:0] key_q, key_d;
    logic [6:0] vel_q, vel_d;
    logic       pend_valid_q, pend_valid_d;
    logic [6:0] pend_key_q, pend_key_d;
    logic [6:0] pend_vel_q, pend_vel_d;
    logic       note_on_q, note_on_d;
    logic       note_off_q, note_off_d;
    logic       active_q, active_d;

    logic       accept;
    logic       dispatch;
    logic       ev_on;
    logic       done_seen;

    assign accept   = in_valid && in_ready_q;
    assign dispatch = (parse_q == P_DISPATCH);
    // Note On with velocity 0 is a Note Off.
    assign ev_on    = rs_on_q && (data2_q != 7'd0);
    // A done that coincides with our own note_off pulse belongs to an
    // envelope that was already finishing; ignoring it guarantees at least
    // two cycles between note_off and the following note_on.
    assign done_seen = env_done && (voice_q == V_REL) && !note_off_q;

    // ---------------- parser next state ----------------
    always_comb begin
        parse_d    = parse_q;
        rs_valid_d = rs_valid_q;
        rs_on_d    = rs_on_q;
        data1_d    = data1_q;
        data2_d    = data2_q;

        if (dispatch) begin
            parse_d = P_STATUS;
        end else if (accept) begin
            if (in_data[7]) begin
                if (in_data[7:3] == 5'b11111) begin
                    // Real-time byte: transparent to the parser.
                    parse_d = parse_q;
                end else if ((in_data[7:5] == 3'b100) && (in_data[3:0] == CH)) begin
                    // 0x8n / 0x9n on our channel: new running status.
                    rs_valid_d = 1'b1;
                    rs_on_d    = in_data[4];
                    parse_d    = P_DATA1;
                end else begin
                    // Any other status (other channel, other type, system
                    // common): following data bytes are not ours.
                    rs_valid_d = 1'b0;
                    parse_d    = P_STATUS;
                end
            end else begin
                case (parse_q)
                    P_STATUS: begin
                        if (rs_valid_q) begin
                            data1_d = in_data[6:0];
                            parse_d = P_DATA2;
                        end
                    end
                    P_DATA1: begin
                        data1_d = in_data[6:0];
                        parse_d = P_DATA2;
                    end
                    P_DATA2: begin
                        data2_d = in_data[6:0];
                        parse_d = P_DISPATCH;
                    end
                    default: parse_d = parse_q;
                endcase
            end
        end

        in_ready_d = (parse_d != P_DISPATCH);
    end

    // ---------------- voice next state ----------------
    always_comb begin
        voice_d      = voice_q;
        key_d        = key_q;
        vel_d        = vel_q;
        pend_valid_d = pend_valid_q;
        pend_key_d   = pend_key_q;
        pend_vel_d   = pend_vel_q;
        note_on_d    = 1'b0;
        note_off_d   = 1'b0;

        // Event first, so that a simultaneous env_done sees the updated
        // pending slot.
        if (dispatch) begin
            case (voice_q)
                V_IDLE: begin
                    if (ev_on) begin
                        key_d     = data1_q;
                        vel_d     = data2_q;
                        note_on_d = 1'b1;
                        voice_d   = V_ON;
                    end
                end
                V_ON: begin
                    if (ev_on) begin
                        pend_valid_d = 1'b1;
                        pend_key_d   = data1_q;
                        pend_vel_d   = data2_q;
                        note_off_d   = 1'b1;
                        voice_d      = V_REL;
                    end else if (data1_q == key_q) begin
                        note_off_d = 1'b1;
                        voice_d    = V_REL;
                    end
                end
                V_REL: begin
                    if (ev_on) begin
                        pend_valid_d = 1'b1;
                        pend_key_d   = data1_q;
                        pend_vel_d   = data2_q;
                    end else if (pend_valid_q && (data1_q == pend_key_q)) begin
                        pend_valid_d = 1'b0;
                    end
                end
                default: voice_d = V_IDLE;
            endcase
        end

        if (done_seen) begin
            if (pend_valid_d) begin
                key_d        = pend_key_d;
                vel_d        = pend_vel_d;
                pend_valid_d = 1'b0;
                note_on_d    = 1'b1;
                voice_d      = V_ON;
            end else begin
                voice_d = V_IDLE;
            end
        end

        active_d = (voice_d != V_IDLE);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            parse_q      <= P_STATUS;
            rs_valid_q   <= 1'b0;
            rs_on_q      <= 1'b0;
            data1_q      <= 7'd0;
            data2_q      <= 7'd0;
            in_ready_q   <= 1'b0;
            voice_q      <= V_IDLE;
            key_q        <= 7'd0;
            vel_q        <= 7'd0;
            pend_valid_q <= 1'b0;
            pend_key_q   <= 7'd0;
            pend_vel_q   <= 7'd0;
            note_on_q    <= 1'b0;
            note_off_q   <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            parse_q      <= parse_d;
            rs_valid_q   <= rs_valid_d;
            rs_on_q      <= rs_on_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            in_ready_q   <= in_ready_d;
            voice_q      <= voice_d;
            key_q        <= key_d;
            vel_q        <= vel_d;
            pend_valid_q <= pend_valid_d;
            pend_key_q   <= pend_key_d;
            pend_vel_q   <= pend_vel_d;
            note_on_q    <= note_on_d;
            note_off_q   <= note_off_d;
            active_q     <= active_d;
        end
    end

    assign in_ready = in_ready_q;
    assign note_on  = note_on_q;
    assign note_off = note_off_q;
    assign key      = key_q;
    assign velocity = vel_q;
    assign active   = active_q;

    // ---------------- simulation-only consistency check ----------------
    // The generator should report busy shortly after the voice leaves idle;
    // three consecutive active-but-not-busy cycles indicate a broken link.
`ifndef SYNTHESIS
    logic [1:0] busy_gap_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            busy_gap_q <= 2'd0;
        end else if (active_q && !env_busy) begin
            if (busy_gap_q != 2'd3) begin
                busy_gap_q <= busy_gap_q + 2'd1;
            end
        end else begin
            busy_gap_q <= 2'd0;
        end
    end

    always @(posedge clk) begin
        if (rst_b) begin
            assert (busy_gap_q != 2'd3)
                else $error("note_event_controller: active without env_busy for more than 2 cycles");
        end
    end
`endif

endmodule

// File: tb/tb_note_event_controller.sv
// ---------------------------------------------------------------------------
// tb_note_event_controller
//
// Scoreboard bench for note_event_controller (CHANNEL=0). Each stimulus step
// pushes the pulses it should cause; a negedge monitor pops and compares
// every note_on / note_off pulse the DUT produces.
// ---------------------------------------------------------------------------
module tb_note_event_controller;

    logic       clk;
    logic       rst_b;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       env_done;
    logic       env_busy;
    logic       note_on;
    logic       note_off;
    logic [6:0] key;
    logic [6:0] velocity;
    logic       active;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit       is_on;
        bit [6:0] key;
        bit [6:0] vel;
    } exp_t;

    exp_t exp_q[$];

    note_event_controller #(.CHANNEL(0)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .env_done (env_done),
        .env_busy (env_busy),
        .note_on  (note_on),
        .note_off (note_off),
        .key      (key),
        .velocity (velocity),
        .active   (active)
    );

    // Generator model: busy whenever a voice is sounding.
    assign env_busy = active;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input bit on, input bit [6:0] k, input bit [6:0] v);
        exp_t e;
        e.is_on = on;
        e.key   = k;
        e.vel   = v;
        return e;
    endfunction

    // ---------------- pulse monitor ----------------
    logic prev_on  = 1'b0;
    logic prev_off = 1'b0;

    always @(negedge clk) begin
        if (rst_b) begin
            if (note_on && note_off) check("on_off_overlap", 1, 0);
            if (note_on && prev_on) check("on_width", 1, 0);
            if (note_off && prev_off) check("off_width", 1, 0);
            if (note_on || note_off) begin
                $display("[TB] pulse %s key=0x%0h vel=0x%0h", note_on ? "on " : "off",
                         key, velocity);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_type", int'(note_on), int'(e.is_on));
                    check("pulse_key", int'(key), int'(e.key));
                    check("pulse_vel", int'(velocity), int'(e.vel));
                end
            end
            prev_on  <= note_on;
            prev_off <= note_off;
        end else begin
            prev_on  <= 1'b0;
            prev_off <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drives one byte from a negedge; returns at the negedge after the
    // accepting posedge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("[TB] byte 0x%02h", b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_done();
        env_done = 1'b1;
        @(negedge clk);
        env_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_note_on"}, int'(note_on), 0);
        check({tag, "_note_off"}, int'(note_off), 0);
        check({tag, "_key"}, int'(key), 0);
        check({tag, "_vel"}, int'(velocity), 0);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_ready"}, int'(in_ready), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_b    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        env_done = 1'b0;
        idle(3);
        check_reset_outputs("rst");
        rst_b = 1'b1;
        idle(2);
        check("ready_after_rst", int'(in_ready), 1);

        // Basic Note On
        exp_q.push_back(mk(1, 7'h3C, 7'h64));
        send(8'h90); send(8'h3C); send(8'h64);
        check("ready_in_dispatch", int'(in_ready), 0);
        drain("drain_on1");
        check("active_on1", int'(active), 1);

        // Running-status Note On vel 0 -> note_off, then done -> idle
        exp_q.push_back(mk(0, 7'h3C, 7'h64));
        send(8'h3C); send(8'h00);
        drain("drain_off1");
        idle(5);
        pulse_done();
        idle(2);
        check("active_after_done", int'(active), 0);

        // Retrigger: second Note On while sounding
        exp_q.push_back(mk(1, 7'h3C, 7'h64));
        send(8'h90); send(8'h3C); send(8'h64);
        drain("drain_on2");
        exp_q.push_back(mk(0, 7'h3C, 7'h64));
        send(8'h40); send(8'h50);
        drain("drain_retrig_off");
        check("key_held", int'(key), 'h3C);
        idle(3);
        exp_q.push_back(mk(1, 7'h40, 7'h50));
        pulse_done();
        drain("drain_pending_on");
        check("key_pending", int'(key), 'h40);
        check("vel_pending", int'(velocity), 'h50);

        // Explicit Note Off 0x80 for the current key, then release
        exp_q.push_back(mk(0, 7'h40, 7'h50));
        send(8'h80); send(8'h40); send(8'h00);
        drain("drain_off2");
        idle(3);
        pulse_done();
        idle(2);
        check("active_idle2", int'(active), 0);

        // Other channel: nothing happens
        send(8'h91); send(8'h3C); send(8'h64); send(8'h3E); send(8'h64);
        idle(5);
        check("other_ch_active", int'(active), 0);

        // Real-time bytes interleaved
        exp_q.push_back(mk(1, 7'h3C, 7'h64));
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h64);
        drain("drain_rt_on");
        check("rt_key", int'(key), 'h3C);

        // Pending 0x40, then Note Off 0x40 dispatched together with done
        exp_q.push_back(mk(0, 7'h3C, 7'h64));
        send(8'h40); send(8'h20);
        drain("drain_pend_off");
        idle(3);
        send(8'h80); send(8'h40); send(8'h00);
        pulse_done();             // env_done high in the dispatch cycle
        idle(3);
        check("cancel_active", int'(active), 0);

        // Reset while sounding and mid-message
        exp_q.push_back(mk(1, 7'h3C, 7'h64));
        send(8'h90); send(8'h3C); send(8'h64);
        drain("drain_on3");
        send(8'h90); send(8'h3C);
        rst_b = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_b = 1'b1;
        idle(3);
        send(8'h45); send(8'h10);
        idle(5);
        check("post_rst_active", int'(active), 0);
        check("post_rst_key", int'(key), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 0);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

endmodule
